// File: rtl/demux_1_to_4_6_bit_reg.sv
// Write-side 1-to-4 demux. A (data, sel) request is staged for one cycle and then
// committed into one of four held output registers, with sticky written flags and a commit pulse.
module demux_1_to_4_6_bit_reg #(
  parameter int                 WIDTH   = 6,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             clr,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       written,
  output logic             wr_done,
  output logic [3:0]       wr_onehot
);

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] stg_data_q;
  logic [1:0]       stg_sel_q;
  logic [WIDTH-1:0] regs_q [4];
  logic [3:0]       written_q;
  logic             wr_done_q;
  logic [3:0]       wr_onehot_q;
  logic             accept;
  logic             commit;

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == IDLE) && !clr;
    accept   = in_valid && in_ready;
    commit   = (state_q == COMMIT) && !clr;
    case (state_q)
      IDLE:    if (accept) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A clear in any state abandons the staged write; X on clr also lands here.
    if (clr || $isunknown(clr)) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stg_data_q  <= '0;
      stg_sel_q   <= '0;
      written_q   <= '0;
      wr_done_q   <= 1'b0;
      wr_onehot_q <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= RST_VAL;
    end else begin
      state_q     <= state_d;
      wr_done_q   <= commit;
      wr_onehot_q <= commit ? (4'b0001 << stg_sel_q) : 4'b0000;
      if (accept) begin
        stg_data_q <= in_data;
        stg_sel_q  <= in_sel;
      end
      if (clr) begin
        written_q <= '0;
        for (int i = 0; i < 4; i++) regs_q[i] <= RST_VAL;
      end else if (commit) begin
        regs_q[stg_sel_q]    <= stg_data_q;
        written_q[stg_sel_q] <= 1'b1;
      end
    end
  end

  assign o0        = regs_q[0];
  assign o1        = regs_q[1];
  assign o2        = regs_q[2];
  assign o3        = regs_q[3];
  assign written   = written_q;
  assign wr_done   = wr_done_q;
  assign wr_onehot = wr_onehot_q;

endmodule

// File: tb/tb_demux_1_to_4_6_bit_reg.sv
// Bench for demux_1_to_4_6_bit_reg: directed scenarios plus a randomized run
// compared against a register-file/pending-write model.
module tb_demux_1_to_4_6_bit_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic [1:0] in_sel;
  logic       clr;
  logic [5:0] o0, o1, o2, o3;
  logic [3:0] written;
  logic       wr_done;
  logic [3:0] wr_onehot;

  int total = 0;
  int bad   = 0;

  logic [5:0] exp_o [4];
  logic [3:0] exp_wr;

  always #5 clk = ~clk;

  demux_1_to_4_6_bit_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .clr(clr),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .written(written), .wr_done(wr_done), .wr_onehot(wr_onehot)
  );

  function automatic logic [23:0] exp_bus();
    return {exp_o[3], exp_o[2], exp_o[1], exp_o[0]};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) exp_o[i] = 6'h00;
    exp_wr = 4'b0000;
  endfunction

  function automatic void model_write(input logic [1:0] s, input logic [5:0] d);
    exp_o[s]  = d;
    exp_wr[s] = 1'b1;
  endfunction

  // Present one request for exactly one accepting edge; returns 1 ns after that edge.
  task automatic drive_write(input logic [1:0] s, input logic [5:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_sel = s; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'b00; in_data = 6'h00; clr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    drive_write(2'd0, 6'h11);
    @(posedge clk); #1;
    total++; if (o0 !== 6'h11 || wr_done !== 1'b1) begin bad++; $display("FAIL reset_prewrite: o0=%h done=%b want 11/1", o0, wr_done); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({o3, o2, o1, o0} !== 24'h0) begin bad++; $display("FAIL reset_async_regs: got %h want 0", {o3, o2, o1, o0}); end
    total++; if ({written, wr_done, wr_onehot} !== 9'b0) begin bad++; $display("FAIL reset_async_flags: got %b want 0", {written, wr_done, wr_onehot}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_write_o2();
    drive_write(2'd2, 6'h2A);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL w2_ready_commit: got %b want 0", in_ready); end
    total++; if (exp_bus() !== {o3, o2, o1, o0}) begin bad++; $display("FAIL w2_not_early: got %h want %h", {o3, o2, o1, o0}, exp_bus()); end
    @(posedge clk); #1;
    model_write(2'd2, 6'h2A);
    total++; if ({o3, o2, o1, o0} !== exp_bus()) begin bad++; $display("FAIL w2_regs: got %h want %h", {o3, o2, o1, o0}, exp_bus()); end
    total++; if (wr_done !== 1'b1 || wr_onehot !== 4'b0100) begin bad++; $display("FAIL w2_pulse: got %b/%b want 1/0100", wr_done, wr_onehot); end
    total++; if (written !== 4'b0100) begin bad++; $display("FAIL w2_written: got %b want 0100", written); end
    @(posedge clk); #1;
    total++; if (wr_done !== 1'b0 || wr_onehot !== 4'b0000 || in_ready !== 1'b1) begin bad++; $display("FAIL w2_pulse_end: got %b/%b/%b want 0/0000/1", wr_done, wr_onehot, in_ready); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_clear();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 6'h3F;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (wr_done === 1'b1) pulses++;
      if (k == 0) begin in_sel = 2'd3; in_data = 6'h01; end
      if (k == 2) in_valid = 1'b0;
    end
    model_write(2'd0, 6'h3F);
    model_write(2'd3, 6'h01);
    total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    total++; if ({o3, o2, o1, o0} !== exp_bus()) begin bad++; $display("FAIL b2b_regs: got %h want %h", {o3, o2, o1, o0}, exp_bus()); end
    total++; if (written !== 4'b1001) begin bad++; $display("FAIL b2b_written: got %b want 1001", written); end
  endtask

  task automatic test_clear_vs_commit();
    drive_write(2'd1, 6'h15);
    clr = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
    #1;
    total++; if ({o3, o2, o1, o0} !== exp_bus()) begin bad++; $display("FAIL clr_regs: got %h want %h", {o3, o2, o1, o0}, exp_bus()); end
    total++; if (wr_done !== 1'b0 || wr_onehot !== 4'b0000 || written !== 4'b0000) begin bad++; $display("FAIL clr_flags: got %b/%b/%b want 0/0000/0000", wr_done, wr_onehot, written); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL clr_idle: got %b want 1", in_ready); end
  endtask

  task automatic test_overwrite();
    drive_write(2'd2, 6'h09);
    @(posedge clk); #1;
    model_write(2'd2, 6'h09);
    drive_write(2'd1, 6'h07);
    @(posedge clk); #1;
    model_write(2'd1, 6'h07);
    drive_write(2'd1, 6'h38);
    @(posedge clk); #1;
    model_write(2'd1, 6'h38);
    total++; if ({o3, o2, o1, o0} !== exp_bus()) begin bad++; $display("FAIL ovw_regs: got %h want %h", {o3, o2, o1, o0}, exp_bus()); end
    total++; if (written !== exp_wr) begin bad++; $display("FAIL ovw_written: got %b want %b", written, exp_wr); end
  endtask

  task automatic test_reset_in_commit();
    drive_write(2'd3, 6'h2C);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    total++; if ({o3, o2, o1, o0} !== exp_bus() || written !== 4'b0000) begin bad++; $display("FAIL rstc_regs: got %h/%b want %h/0000", {o3, o2, o1, o0}, written, exp_bus()); end
    @(posedge clk); #1;
    total++; if (wr_done !== 1'b0 || o3 !== 6'h00) begin bad++; $display("FAIL rstc_no_commit: got %b/%h want 0/00", wr_done, o3); end
    @(negedge clk); rst_n = 1'b1;
    drive_write(2'd0, 6'h05);
    @(posedge clk); #1;
    model_write(2'd0, 6'h05);
    total++; if ({o3, o2, o1, o0} !== exp_bus() || wr_onehot !== 4'b0001) begin bad++; $display("FAIL rstc_resume: got %h/%b want %h/0001", {o3, o2, o1, o0}, wr_onehot, exp_bus()); end
    @(posedge clk); #1;
  endtask

  // Model: a register file plus at most one pending write waiting to be committed.
  task automatic test_random();
    bit         pend = 1'b0;
    logic [1:0] pend_sel = 2'd0;
    logic [5:0] pend_data = 6'h00;
    bit         exp_done;
    logic [3:0] exp_oh;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_sel   = 2'($urandom);
      in_data  = 6'($urandom);
      clr      = ($urandom_range(0, 9) == 0);
      #1;
      total++; if (in_ready !== (!pend && !clr)) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, in_ready, !pend && !clr); end
      @(posedge clk);
      exp_done = 1'b0; exp_oh = 4'b0000;
      if (clr) begin
        model_clear();
        pend = 1'b0;
      end else if (pend) begin
        model_write(pend_sel, pend_data);
        exp_done = 1'b1; exp_oh = 4'b0001 << pend_sel;
        pend = 1'b0;
      end else if (in_valid) begin
        pend = 1'b1; pend_sel = in_sel; pend_data = in_data;
      end
      #1;
      total++;
      if ({o3, o2, o1, o0} !== exp_bus() || written !== exp_wr || wr_done !== exp_done || wr_onehot !== exp_oh) begin
        bad++;
        $display("FAIL rnd_state[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", n,
                 {o3, o2, o1, o0}, written, wr_done, wr_onehot, exp_bus(), exp_wr, exp_done, exp_oh);
      end
    end
    @(negedge clk); in_valid = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_o2();
    test_back_to_back();
    test_clear_vs_commit();
    test_overwrite();
    test_reset_in_commit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
